// File: rtl/bus_mem_slave.sv
// bus_mem_slave: T1/T2/TW/R/W/T4 bus-cycle decoder that services reads and
// writes from a local storage array inside a BASE..BASE+DEPTH-1 window.
// Several instances with different BASE values may share one bus.
module bus_mem_slave #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 1024,
  parameter int BASE        = 0,
  parameter int IO_SPACE    = 0,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Address,
  input  logic              ALE,
  input  logic              CS,
  input  logic              MIO,
  input  logic              RD,
  input  logic              WR,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataOE,
  output logic              READY,
  output logic              ERR
);

  localparam int OFF_W = $clog2(DEPTH);

  // Window bounds carry one extra bit so BASE+DEPTH never wraps.
  localparam logic [ADDR_W:0]   WIN_LO  = (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0]   WIN_HI  = (ADDR_W+1)'(BASE) + (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic              MIO_REQ = (IO_SPACE == 0) ? 1'b1 : 1'b0;
  localparam logic [3:0]        WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [5:0] {
    S_T1 = 6'b000001,
    S_T2 = 6'b000010,
    S_TW = 6'b000100,
    S_R  = 6'b001000,
    S_W  = 6'b010000,
    S_T4 = 6'b100000
  } state_e;

  state_e              state_q, state_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_wr_q, op_wr_d;
  logic [DATA_W-1:0]   dout_q;
  logic                err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W:0]     addr_ext;
  logic                in_win;
  logic                hit;
  logic [OFF_W-1:0]    off_in;
  logic [DATA_W-1:0]   rd_word;

  // Address decode for this device's window and space.
  always_comb begin
    addr_ext = {1'b0, Address};
    in_win   = (addr_ext >= WIN_LO) && (addr_ext < WIN_HI);
    hit      = ALE & ~CS & (MIO == MIO_REQ) & in_win;
    off_in   = OFF_W'(Address - BASE_A);
    rd_word  = mem[off_q];
  end

  // Next-state logic; dual strobe in T2 aborts with a one-cycle ERR.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    err_d   = 1'b0;
    case (state_q)
      S_T1: begin
        if (hit) begin
          state_d = S_T2;
          off_d   = off_in;
        end
      end
      S_T2: begin
        if (!RD && !WR) begin
          state_d = S_T4;
          err_d   = 1'b1;
        end else if (!RD || !WR) begin
          op_wr_d = RD;  // RD high here means the write strobe is the active one
          if (WAIT_STATES == 0) begin
            state_d = RD ? S_W : S_R;
          end else begin
            state_d = S_TW;
            cnt_d   = WS_INIT;
          end
        end else if (hit) begin
          off_d = off_in;
        end
      end
      S_TW: begin
        if (cnt_q == 4'd0) state_d = op_wr_q ? S_W : S_R;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_R:  state_d = S_T4;
      S_W:  state_d = S_T4;
      S_T4: begin
        if (hit) begin
          state_d = S_T2;
          off_d   = off_in;
        end else begin
          state_d = S_T1;
        end
      end
      default: state_d = S_T1;
    endcase
  end

  // Control registers; read data is captured in R so DataOut holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_T1;
      off_q   <= '0;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      if (state_q == S_R) dout_q <= rd_word;
    end
  end

  // Storage is never cleared; a reset during the W cycle suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_W) mem[off_q] <= DataIn;
  end

  // Bus-facing outputs.
  always_comb begin
    READY   = (state_q != S_TW);
    DataOE  = (state_q == S_R);
    DataOut = (state_q == S_R) ? rd_word : dout_q;
    ERR     = err_d;
  end

endmodule

// File: tb/tb_bus_mem_slave.sv
// Bench: three slaves share one bus (memory @0, memory @0x40000, I/O @0 with
// no wait states). A driver issues cycles and pushes expectations into
// per-device queues; a monitor pops them whenever a device drives data or ERR.
module tb_bus_mem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] Address;
  logic        ALE, CS, MIO, RD, WR;
  logic [7:0]  DataIn;
  logic [7:0]  dout [3];
  logic [2:0]  doe, rdy, errs;

  int checks = 0;
  int errors = 0;

  bit [7:0]    ref_mem [3][1024];
  int unsigned wlist   [3][$];
  bit [7:0]    rd_q    [3][$];
  bit          err_q   [3][$];

  always #5 clk = ~clk;

  bus_mem_slave u0 (
    .clk(clk), .rst(rst), .Address(Address), .ALE(ALE), .CS(CS), .MIO(MIO),
    .RD(RD), .WR(WR), .DataIn(DataIn), .DataOut(dout[0]), .DataOE(doe[0]),
    .READY(rdy[0]), .ERR(errs[0]));

  bus_mem_slave #(.BASE(32'h40000)) u1 (
    .clk(clk), .rst(rst), .Address(Address), .ALE(ALE), .CS(CS), .MIO(MIO),
    .RD(RD), .WR(WR), .DataIn(DataIn), .DataOut(dout[1]), .DataOE(doe[1]),
    .READY(rdy[1]), .ERR(errs[1]));

  bus_mem_slave #(.IO_SPACE(1), .WAIT_STATES(0)) u2 (
    .clk(clk), .rst(rst), .Address(Address), .ALE(ALE), .CS(CS), .MIO(MIO),
    .RD(RD), .WR(WR), .DataIn(DataIn), .DataOut(dout[2]), .DataOE(doe[2]),
    .READY(rdy[2]), .ERR(errs[2]));

  function automatic int unsigned base_of(int i);
    return (i == 1) ? 32'h40000 : 32'h0;
  endfunction
  function automatic bit mio_of(int i);
    return (i == 2) ? 1'b0 : 1'b1;
  endfunction
  function automatic int ws_of(int i);
    return (i == 2) ? 0 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete bus cycle. kind: 0 = read, 1 = write, 2 = dual strobe.
  task automatic cycle(input int inst, input int unsigned off, input int kind, input bit [7:0] wd);
    int lows = 0;
    step();
    Address = 20'(base_of(inst) + off);
    MIO = mio_of(inst); ALE = 1'b1; CS = 1'b0;
    step();
    ALE = 1'b0; CS = 1'b1; DataIn = wd;
    case (kind)
      0: begin RD = 1'b0; rd_q[inst].push_back(ref_mem[inst][off]); end
      1: begin WR = 1'b0; ref_mem[inst][off] = wd; wlist[inst].push_back(off); end
      default: begin RD = 1'b0; WR = 1'b0; err_q[inst].push_back(1'b1); end
    endcase
    for (int k = 1; k <= ws_of(inst) + 2; k++) begin
      step();
      if (!rdy[inst]) lows++;
    end
    RD = 1'b1; WR = 1'b1;
    chk("wait-state count", lows, (kind == 2) ? 0 : ws_of(inst));
    if (kind == 0) begin
      step();
      chk("DataOut hold after read", dout[inst], ref_mem[inst][off]);
      chk("DataOE low after read", doe[inst], 1'b0);
    end
  endtask

  // Cycle aimed outside every window: nobody may react.
  task automatic nohit(input int unsigned addr, input bit mio);
    step();
    Address = 20'(addr); MIO = mio; ALE = 1'b1; CS = 1'b0;
    step();
    ALE = 1'b0; CS = 1'b1; RD = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("no-hit READY", rdy, 3'b111);
      chk("no-hit DataOE", doe, 3'b000);
    end
    RD = 1'b1;
  endtask

  // Monitor: every DataOE cycle and every ERR pulse must match a queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (doe[i] === 1'b1) begin
          if (rd_q[i].size() == 0) chk($sformatf("unexpected DataOE dev%0d", i), 1, 0);
          else chk($sformatf("read data dev%0d", i), dout[i], rd_q[i].pop_front());
        end
        if (errs[i] === 1'b1) begin
          if (err_q[i].size() == 0) chk($sformatf("unexpected ERR dev%0d", i), 1, 0);
          else chk($sformatf("ERR pulse dev%0d", i), errs[i], err_q[i].pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int inst, r;
    int unsigned off;
    rst = 1'b1; Address = '0; ALE = 1'b0; CS = 1'b1; MIO = 1'b1;
    RD = 1'b1; WR = 1'b1; DataIn = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("reset READY", rdy, 3'b111);
    chk("reset DataOE", doe, 3'b000);
    chk("reset ERR", errs, 3'b000);
    chk("reset DataOut dev0", dout[0], 8'h00);
    chk("reset DataOut dev1", dout[1], 8'h00);

    // Basic write then read on the default device.
    cycle(0, 'h10, 1, 8'hA5);
    cycle(0, 'h10, 0, 8'h00);

    // Window edges of the 0x40000 device, plus misses.
    cycle(1, 'h3FF, 1, 8'h3C);
    cycle(1, 'h000, 1, 8'hC3);
    cycle(1, 'h3FF, 0, 8'h00);
    cycle(1, 'h000, 0, 8'h00);
    nohit(32'h40400, 1'b1);
    nohit(32'h3FFFF, 1'b1);
    nohit(32'h40010, 1'b0);

    // Back-to-back on the zero-wait I/O device: ALE in T4 chains into T2.
    step(); Address = 20'h3; MIO = 1'b0; ALE = 1'b1; CS = 1'b0;
    step(); ALE = 1'b0; CS = 1'b1; WR = 1'b0; DataIn = 8'h5A;
    ref_mem[2][3] = 8'h5A; wlist[2].push_back(3);
    chk("b2b READY T2", rdy[2], 1'b1);
    step(); chk("b2b READY W", rdy[2], 1'b1);
    step(); WR = 1'b1; Address = 20'h3; ALE = 1'b1; CS = 1'b0;
    chk("b2b READY T4", rdy[2], 1'b1);
    step(); ALE = 1'b0; CS = 1'b1; RD = 1'b0; rd_q[2].push_back(8'h5A);
    step(); chk("b2b DataOE in R", doe[2], 1'b1); chk("b2b READY R", rdy[2], 1'b1);
    step(); RD = 1'b1; chk("b2b DataOE T4", doe[2], 1'b0);
    step();

    // Dual strobe: error, no access.
    cycle(0, 'h10, 2, 8'h77);
    cycle(0, 'h10, 0, 8'h00);

    // Reset during the wait states of a write must not commit it.
    cycle(0, 'h20, 1, 8'h11);
    step(); Address = 20'h20; MIO = 1'b1; ALE = 1'b1; CS = 1'b0;
    step(); ALE = 1'b0; CS = 1'b1; WR = 1'b0; DataIn = 8'hFF;
    step(); chk("TW READY low", rdy[0], 1'b0); rst = 1'b1;
    step(); rst = 1'b0; WR = 1'b1;
    chk("post-reset READY", rdy, 3'b111);
    chk("post-reset DataOE", doe, 3'b000);
    cycle(0, 'h20, 0, 8'h00);

    // Randomised traffic against the reference memories.
    for (int n = 0; n < 80; n++) begin
      inst = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      if (wlist[inst].size() == 0 || r < 4) begin
        cycle(inst, $urandom_range(0, 1023), 1, 8'($urandom));
      end else begin
        off = wlist[inst][$urandom_range(0, wlist[inst].size() - 1)];
        cycle(inst, off, (r < 9) ? 0 : 2, 8'($urandom));
      end
    end

    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reads outstanding dev%0d", i), rd_q[i].size(), 0);
      chk($sformatf("ERR outstanding dev%0d", i), err_q[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
- Parametrised successor of the single-bank bus-cycle FSM. Decodes a multiplexed-style T1/T2/T3/T4 processor bus cycle and actually services it from an internal storage array.
- Adds a base/depth address window, M/IO space selection, programmable wait states with READY, and protocol-error detection.
- Sits on the CPU local bus as one memory or I/O device. Several instances, each with a different BASE, share the bus.

Parameters:
- ADDR_W, 20, width of Address.
- DATA_W, 8, data width, and width of each storage word.
- DEPTH, 1024, number of words in the window; power of two, at least 2.
- BASE, 0, first decoded address; must be a multiple of DEPTH.
- IO_SPACE, 0, 0 = respond only when MIO=1 (memory); 1 = respond only when MIO=0 (I/O).
- WAIT_STATES, 2, number of TW cycles inserted before R/W; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Address  in  ADDR_W  bus address; valid and sampled only while ALE=1.
- ALE  in  1  address latch enable, active high.
- CS  in  1  chip select, active low.
- MIO  in  1  1 = memory cycle, 0 = I/O cycle.
- RD  in  1  read strobe, active low.
- WR  in  1  write strobe, active low.
- DataIn  in  DATA_W  write data; sampled in state W.
- DataOut  out  DATA_W  read data.
- DataOE  out  1  drive enable for DataOut; high only in state R.
- READY  out  1  low while wait states are being inserted.
- ERR  out  1  one-cycle pulse on a protocol error.

Behaviour:
- hit = ALE & !CS & (MIO == !IO_SPACE) & (BASE <= Address < BASE+DEPTH).
- On hit, Address-BASE is latched into the offset register.
- States, one-hot: T1, T2, TW, R, W, T4.
- Reset: state=T1, DataOE=0, DataOut=0, READY=1, ERR=0, offset=0, wait counter=0.
  - Storage contents are not cleared.
  - Reset asserted mid-cycle aborts the cycle; a write in progress is not committed.
- T1: hit -> T2, latch offset; otherwise stay in T1.
- T2:
  - RD=0 & WR=0 -> T4 with ERR=1 for that cycle; no access.
  - RD=0 -> R if WAIT_STATES=0, else TW with counter=WAIT_STATES-1, op=read.
  - WR=0 -> W or TW likewise, op=write.
  - hit (ALE reasserted) with no strobe -> stay in T2 and relatch offset.
  - Otherwise stay in T2 indefinitely. There is no timeout.
- TW:
  - READY=0.
  - Counter decrements each cycle; at counter=0 go to R or W per op.
  - The strobe is not re-checked in TW.
  - WAIT_STATES=N gives exactly N cycles in TW.
- R:
  - DataOE=1; DataOut=mem[offset], presented combinationally from the array read.
  - READY=1. Next state is T4.
- W:
  - mem[offset] <= DataIn at the rising edge ending W. Next state is T4.
- T4:
  - DataOE=0; DataOut holds its last value.
  - hit -> T2, with back-to-back cycle support and offset relatched; otherwise -> T1.
- READY is 1 in every state except TW.
- ERR is 0 except for the one cycle that leaves T2 on a dual strobe.
- Latency, strobe sampled low in T2 to data valid: WAIT_STATES+1 cycles.
- No out-of-window response: no hit means no DataOE, no READY drop and no state change.
- Offset width is log2(DEPTH). Address arithmetic uses ADDR_W bits, with no wrap past BASE+DEPTH-1.
- Illegal or unreachable state encodings recover to T1 on the next clock.

Test Plan:
- Default params: write 0xA5 to 0x00010 (ALE+CS=0, MIO=1, then WR=0) -> READY low for 2 cycles; W state; mem[0x10]=0xA5; ERR=0.
- Read 0x00010 with RD=0 -> READY low for 2 cycles, then DataOE=1 and DataOut=0xA5 for exactly 1 cycle, then T4 with DataOE=0.
- Boundary: BASE=0x40000, DEPTH=1024:
  - access 0x403FF -> hits, offset 0x3FF;
  - 0x40400 and 0x3FFFF -> no response (FSM stays in T1, READY=1, DataOE=0);
  - MIO=0 -> no response.
- WAIT_STATES=0, IO_SPACE=1, MIO=0: back-to-back write 0x5A then read of offset 3, with ALE reasserted in T4 -> T4 goes straight to T2; read returns 0x5A; READY never drops.
- Dual strobe: RD=0 and WR=0 in T2 -> ERR=1 for one cycle; goes to T4; mem unchanged; DataOE=0.
- Reset mid-cycle: assert rst while in TW of a write of 0xFF over existing 0x11 -> state=T1, READY=1, DataOE=0 next cycle; a subsequent read returns 0x11.
